// File: rtl/uart_frame_beacon.sv
// Periodic / on-demand multi-byte frame sender driving a byte-wide UART core (transmit, tx_byte, is_transmitting).
// Optional macro UART_FRAME_SEQ_BYTE_EN appends an 8-bit frame sequence number as the final byte.
module uart_frame_beacon #(
  parameter int MSG_LEN       = 4,
  parameter int PERIOD_CYCLES = 12000000,
  parameter int CNT_W         = $clog2(PERIOD_CYCLES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 trigger,
  input  logic [8*MSG_LEN-1:0] msg_data,
  input  logic                 tx_busy,
  output logic                 tx_start,
  output logic [7:0]           tx_byte,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun
);

`ifdef UART_FRAME_SEQ_BYTE_EN
  localparam int FRAME_LEN = MSG_LEN + 1;
`else
  localparam int FRAME_LEN = MSG_LEN;
`endif
  localparam int               IDX_W    = $clog2(MSG_LEN + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYCLES - 1);

  // IDLE: wait for start | LOAD: present byte | WAIT_ACK: await tx_busy rise | WAIT_DONE: await tx_busy fall
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_ACK, WAIT_DONE} state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx, idx_nxt;
  logic [8*FRAME_LEN-1:0] frame_q, frame_in;
  logic                   tick, accept;

  assign tick = enable && (cnt == CNT_LAST);
  assign busy = (state != IDLE);

`ifdef UART_FRAME_SEQ_BYTE_EN
  logic [7:0] seq;

  assign frame_in = {seq, msg_data};

  always_ff @(posedge clk) begin
    if (!rst_n)          seq <= 8'h00;
    else if (frame_done) seq <= seq + 8'd1;
  end
`else
  assign frame_in = msg_data;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n || !enable)  cnt <= '0;
    else if (cnt == CNT_LAST) cnt <= '0;
    else                    cnt <= cnt + CNT_W'(1);
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    accept     = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (tick || trigger) begin
          accept    = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD:     state_nxt = WAIT_ACK;
      WAIT_ACK: if (tx_busy) state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (idx == LAST_IDX) begin
            idx_nxt    = '0;
            frame_done = 1'b1;
            state_nxt  = IDLE;
          end else begin
            idx_nxt   = idx + 1'b1;
            state_nxt = LOAD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // tx_start and tx_byte are registered out of LOAD so the core sees both together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      frame_q  <= '0;
      tx_start <= 1'b0;
      tx_byte  <= 8'h00;
      overrun  <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      tx_start <= (state == LOAD);
      if (accept)
        frame_q <= frame_in;
      if (state == LOAD)
        tx_byte <= frame_q[{idx, 3'b000} +: 8];
      if (tick && (state != IDLE))
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_frame_beacon.sv
// Scoreboard bench for uart_frame_beacon: stimulus queues expected bytes/cycles, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_uart_frame_beacon;
  localparam int MSG_LEN = 2;
  localparam int PERIOD  = 1000;
`ifdef UART_FRAME_SEQ_BYTE_EN
  localparam int FLEN  = MSG_LEN + 1;
  localparam int NRAND = 258;
`else
  localparam int FLEN  = MSG_LEN;
  localparam int NRAND = 20;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n, enable, trigger, tx_busy;
  logic [8*MSG_LEN-1:0] msg_data;
  logic                 tx_start, busy, frame_done, overrun;
  logic [7:0]           tx_byte;

  uart_frame_beacon #(.MSG_LEN(MSG_LEN), .PERIOD_CYCLES(PERIOD)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .trigger(trigger), .msg_data(msg_data),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_byte(tx_byte), .busy(busy),
    .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] b; int cyc; bit first; } exp_t;
  exp_t exp_q[$];

  int checks = 0, failures = 0, cyc = 0;
  int done_cnt = 0, exp_done = 0, seq_model = 0, fall_cyc = 0;
  int ack_min = 1, ack_max = 1, hold_min = 20, hold_max = 20;
  logic [7:0] last_b = 8'h00;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: frame = msg bytes LSB first, then (optionally) sequence = completed frames since reset mod 256.
  task automatic push_frame(input logic [8*MSG_LEN-1:0] msg, input int first_cyc,
                            input int nbytes, input bit completes);
    exp_t e;
    for (int i = 0; i < nbytes; i++) begin
      e.b     = (i < MSG_LEN) ? 8'(msg >> (8*i)) : 8'(seq_model);
      e.cyc   = first_cyc;
      e.first = (i == 0);
      exp_q.push_back(e);
      last_b = e.b;
    end
    if (completes) begin
      seq_model = (seq_model + 1) % 256;
      exp_done++;
    end
  endtask

  task automatic fire(input logic [8*MSG_LEN-1:0] msg);
    @(negedge clk);
    msg_data = msg;
    trigger  = 1'b1;
    push_frame(msg, cyc + 2, FLEN, 1'b1);
    @(negedge clk);
    trigger  = 1'b0;
    msg_data = 16'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || tx_busy || exp_q.size() != 0) && n < budget);
    chk("idle_within_budget", (n < budget), 1);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_tx_byte"}, tx_byte, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // UART core model: is_transmitting rises ack cycles after transmit, stays high hold cycles.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      if (tx_start === 1'b1) begin
        repeat ($urandom_range(ack_max, ack_min) - 1) @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat ($urandom_range(hold_max, hold_min)) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    bit   prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_busy && !tx_busy) fall_cyc = cyc;
      prev_busy = tx_busy;
      if (tx_start === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_tx_start: got tx_byte 0x%0h with no frame pending (cycle %0d)", tx_byte, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", tx_byte, e.b);
          chk("tx_start_cycle", cyc, e.first ? e.cyc : fall_cyc + 2);
        end
      end
      if (frame_done === 1'b1) done_cnt++;
    end
  end

  initial begin
    #3_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int               c;
    logic [8*MSG_LEN-1:0] m;
    rst_n    = 1'b0;
    enable   = 1'b1;
    trigger  = 1'b1;
    msg_data = 16'hAA55;

    // Reset held 3 cycles with enable and trigger asserted
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_cleared("reset");
    end
    rst_n   = 1'b1;
    enable  = 1'b0;
    trigger = 1'b0;

    // One-shot trigger with a dropped second trigger while busy
    ack_min = 1; ack_max = 3; hold_min = 1; hold_max = 5;
    fire(16'($urandom));
    repeat (3) @(negedge clk);
    chk("busy_during_frame", busy, 1);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    wait_idle(500);
    chk("oneshot_overrun", overrun, 0);
    chk("oneshot_frames", done_cnt, exp_done);

    // Periodic: first start 1001 cycles after enable, next exactly 1000 later; trigger coincident with tick
    ack_min = 1; ack_max = 1; hold_min = 20; hold_max = 20;
    @(negedge clk);
    msg_data = 16'hAA55;
    enable   = 1'b1;
    c        = cyc;
    push_frame(16'hAA55, c + 1001, FLEN, 1'b1);
    push_frame(16'hAA55, c + 2001, FLEN, 1'b1);
    repeat (999) @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    repeat (1500) @(negedge clk);
    enable = 1'b0;
    wait_idle(1000);
    chk("periodic_frames", done_cnt, exp_done);
    chk("periodic_overrun", overrun, 0);

    // Overrun: long byte times so the second tick lands mid-frame
    ack_min = 1; ack_max = 3; hold_min = 600; hold_max = 600;
    @(negedge clk);
    m        = 16'($urandom);
    msg_data = m;
    enable   = 1'b1;
    c        = cyc;
    push_frame(m, c + 1001, FLEN, 1'b1);
    repeat (1998) @(negedge clk);
    chk("overrun_before_tick", overrun, 0);
    chk("busy_at_tick", busy, 1);
    repeat (3) @(negedge clk);
    chk("overrun_after_tick", overrun, 1);
    repeat (499) @(negedge clk);
    m        = 16'($urandom);
    msg_data = m;
    push_frame(m, c + 3001, FLEN, 1'b1);
    repeat (550) @(negedge clk);
    enable = 1'b0;
    wait_idle(5000);
    chk("overrun_sticky", overrun, 1);
    chk("overrun_frames", done_cnt, exp_done);

    // Reset during WAIT_DONE of byte 1
    ack_min = 1; ack_max = 3; hold_min = 5; hold_max = 10;
    @(negedge clk);
    m        = 16'($urandom);
    msg_data = m;
    trigger  = 1'b1;
    push_frame(m, cyc + 2, 2, 1'b0);
    @(negedge clk);
    trigger = 1'b0;
    begin
      int n = 0;
      while (!(exp_q.size() == 0 && tx_busy) && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("reach_byte1_wait_done", (n < 200), 1);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_cleared("midframe_reset");
    rst_n     = 1'b1;
    seq_model = 0;
    wait_idle(200);
    fire(16'($urandom));
    wait_idle(300);
    chk("after_reset_frames", done_cnt, exp_done);

    // Randomised one-shot frames, some with a dropped extra trigger
    ack_min = 1; ack_max = 3; hold_min = 1; hold_max = 4;
    for (int k = 0; k < NRAND; k++) begin
      fire(16'($urandom));
      if ($urandom_range(3, 0) == 0) begin
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
      end
      wait_idle(300);
    end
    chk("random_frames", done_cnt, exp_done);
    chk("tx_byte_held_after_frame", tx_byte, last_b);
    chk("random_overrun", overrun, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
